// File: rtl/fb_ctrl_pkg.sv
// Shared types and constants for the 320x240 frame buffer write-side control.
package fb_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CAMERA = 2'd1,
        ST_FILL   = 2'd2
    } fb_state_t;

    localparam int C_FB_PIXELS    = 76800;
    localparam int C_FB_LAST_ADDR = 76799;
    localparam int C_FB_ADDR_W    = 17;

endpackage

// File: rtl/fb_addr_counter.sv
// Sequential frame buffer address generator shared by camera and fill writes.
module fb_addr_counter
    import fb_ctrl_pkg::*;
#(
    parameter int P_LAST = C_FB_LAST_ADDR
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   load_one,
    input  logic                   incr,
    output logic [C_FB_ADDR_W-1:0] count,
    output logic                   at_last
);

    localparam logic [C_FB_ADDR_W-1:0] LAST_VAL = C_FB_ADDR_W'(P_LAST);

    // Clear wins over load-to-1, which wins over increment.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (load_one) begin
            count <= C_FB_ADDR_W'(1);
        end else if (incr) begin
            count <= count + 1'b1;
        end
    end

    assign at_last = (count == LAST_VAL);

endmodule

// File: rtl/fb_write_arbiter_320x240.sv
// Shares the frame buffer RAM write port between the camera stream and the fill engine.
module fb_write_arbiter_320x240
    import fb_ctrl_pkg::*;
#(
    parameter int P_WIDTH  = 320,
    parameter int P_HEIGHT = 240,
    parameter int P_PIXELS = P_WIDTH * P_HEIGHT
) (
    input  logic        piul1Clock,
    input  logic        piul1Reset,
    input  logic        piul1PixValid,
    output logic        poul1PixReady,
    input  logic        piul1PixSof,
    input  logic [23:0] piul24PixData,
    input  logic        piul1FillReq,
    input  logic [23:0] piul24FillColour,
    output logic        poul1FillBusy,
    output logic        poul1FillDone,
    output logic        poul1WriteEnable,
    output logic [16:0] poul17WriteAddress,
    output logic [23:0] poul24WriteData,
    output logic        poul1FrameDone,
    output logic        poul1SyncError,
    output logic [15:0] poul16FrameCount
);

    fb_state_t state, state_next;
    logic        pending;
    logic        reset_q;
    logic [23:0] fill_colour;
    logic [16:0] addr;
    logic        addr_last;
    logic        pix_accept;
    logic        fill_take;

    logic        cnt_clear, cnt_load_one, cnt_incr, pend_clear;
    logic        wr_en_next, frame_done_next, fill_done_next, sync_err_next;
    logic [16:0] wr_addr_next;
    logic [23:0] wr_data_next;

    fb_addr_counter #(
        .P_LAST(P_PIXELS - 1)
    ) u_addr_counter (
        .clk     (piul1Clock),
        .reset   (piul1Reset),
        .clear   (cnt_clear),
        .load_one(cnt_load_one),
        .incr    (cnt_incr),
        .count   (addr),
        .at_last (addr_last)
    );

    // Ready is held low in the cycle right after a sampled reset so every output reads 0 there.
    assign poul1PixReady = !reset_q && (((state == ST_IDLE) && !pending) || (state == ST_CAMERA));
    assign poul1FillBusy = pending || (state == ST_FILL);
    assign pix_accept    = piul1PixValid && poul1PixReady;
    assign fill_take     = piul1FillReq && !poul1FillBusy;

    // State register.
    always_ff @(posedge piul1Clock) begin
        if (piul1Reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decision: a pending fill always beats a new camera frame once in IDLE.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (pending) begin
                    state_next = ST_FILL;
                end else if (pix_accept && piul1PixSof) begin
                    state_next = ST_CAMERA;
                end
            end
            ST_CAMERA: begin
                if (pix_accept && !(piul1PixSof && (addr != '0)) && addr_last) begin
                    state_next = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (addr_last) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Per-state write request, counter control and status pulses for the output registers.
    always_comb begin
        cnt_clear       = 1'b0;
        cnt_load_one    = 1'b0;
        cnt_incr        = 1'b0;
        pend_clear      = 1'b0;
        wr_en_next      = 1'b0;
        wr_addr_next    = '0;
        wr_data_next    = '0;
        frame_done_next = 1'b0;
        fill_done_next  = 1'b0;
        sync_err_next   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pending) begin
                    cnt_clear  = 1'b1;
                    pend_clear = 1'b1;
                end else if (pix_accept && piul1PixSof) begin
                    wr_en_next   = 1'b1;
                    wr_data_next = piul24PixData;
                    cnt_load_one = 1'b1;
                end
            end
            ST_CAMERA: begin
                if (pix_accept) begin
                    wr_en_next   = 1'b1;
                    wr_data_next = piul24PixData;
                    if (piul1PixSof && (addr != '0)) begin
                        cnt_load_one  = 1'b1;
                        sync_err_next = 1'b1;
                    end else begin
                        wr_addr_next = addr;
                        if (addr_last) begin
                            frame_done_next = 1'b1;
                            cnt_clear       = 1'b1;
                        end else begin
                            cnt_incr = 1'b1;
                        end
                    end
                end
            end
            ST_FILL: begin
                wr_en_next   = 1'b1;
                wr_addr_next = addr;
                wr_data_next = fill_colour;
                if (addr_last) begin
                    fill_done_next = 1'b1;
                    cnt_clear      = 1'b1;
                end else begin
                    cnt_incr = 1'b1;
                end
            end
            default: begin
                cnt_clear = 1'b1;
            end
        endcase
    end

    // Fill request capture: only taken while no fill is pending or running.
    always_ff @(posedge piul1Clock) begin
        if (piul1Reset) begin
            pending     <= 1'b0;
            fill_colour <= '0;
        end else if (fill_take) begin
            pending     <= 1'b1;
            fill_colour <= piul24FillColour;
        end else if (pend_clear) begin
            pending <= 1'b0;
        end
    end

    // Registered RAM port, completion pulses and frame counter.
    always_ff @(posedge piul1Clock) begin
        if (piul1Reset) begin
            reset_q            <= 1'b1;
            poul1WriteEnable   <= 1'b0;
            poul17WriteAddress <= '0;
            poul24WriteData    <= '0;
            poul1FrameDone     <= 1'b0;
            poul1FillDone      <= 1'b0;
            poul1SyncError     <= 1'b0;
            poul16FrameCount   <= '0;
        end else begin
            reset_q            <= 1'b0;
            poul1WriteEnable   <= wr_en_next;
            poul17WriteAddress <= wr_addr_next;
            poul24WriteData    <= wr_data_next;
            poul1FrameDone     <= frame_done_next;
            poul1FillDone      <= fill_done_next;
            poul1SyncError     <= sync_err_next;
            if (frame_done_next) begin
                poul16FrameCount <= poul16FrameCount + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fb_write_arbiter_320x240.sv
// Randomized and directed bench for the frame buffer write arbiter, on a reduced 8x4 frame.
module tb_fb_write_arbiter_320x240;

    localparam int W = 8;
    localparam int H = 4;
    localparam int P = W * H;

    logic        clock = 1'b0;
    logic        reset, pixValid, pixSof, fillReq;
    logic [23:0] pixData, fillColour;
    logic        pixReady, fillBusy, fillDone, writeEnable, frameDone, syncError;
    logic [16:0] writeAddress;
    logic [23:0] writeData;
    logic [15:0] frameCount;

    int checkCount = 0;
    int passCount  = 0;

    // Reference model: frame-buffer behaviour expressed as mode/address bookkeeping.
    int          mMode;
    int          mAddr;
    bit          mPending;
    logic [23:0] mColour;
    int          mCount;
    bit          mRstQ;
    bit          modelValid = 0;
    bit          eWe, eFd, eFilld, eSe;
    int          eAddr;
    logic [23:0] eData;

    int cycle = 0;
    int dutWrites, dutFrameDones, dutFillDones, dutSyncErrs, greenWrites;
    int frameDoneCycle, fillDoneCycle;

    always #5 clock = ~clock;

    fb_write_arbiter_320x240 #(
        .P_WIDTH (W),
        .P_HEIGHT(H)
    ) dut (
        .piul1Clock        (clock),
        .piul1Reset        (reset),
        .piul1PixValid     (pixValid),
        .poul1PixReady     (pixReady),
        .piul1PixSof       (pixSof),
        .piul24PixData     (pixData),
        .piul1FillReq      (fillReq),
        .piul24FillColour  (fillColour),
        .poul1FillBusy     (fillBusy),
        .poul1FillDone     (fillDone),
        .poul1WriteEnable  (writeEnable),
        .poul17WriteAddress(writeAddress),
        .poul24WriteData   (writeData),
        .poul1FrameDone    (frameDone),
        .poul1SyncError    (syncError),
        .poul16FrameCount  (frameCount)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", tag, cycle, observed, expected);
        end
    endtask

    task automatic modelStep(input bit rst, input bit valid, input bit sof, input logic [23:0] data,
                             input bit freq, input logic [23:0] col);
        bit rdy, busy, acc, take, newPend;
        eWe = 0; eAddr = 0; eData = '0; eFd = 0; eFilld = 0; eSe = 0;
        if (rst) begin
            mMode = 0; mAddr = 0; mPending = 0; mColour = '0; mCount = 0; mRstQ = 1;
            return;
        end
        rdy     = !mRstQ && ((mMode == 0 && !mPending) || mMode == 1);
        busy    = mPending || mMode == 2;
        acc     = valid && rdy;
        take    = freq && !busy;
        newPend = mPending;
        if (take) begin
            newPend = 1;
            mColour = col;
        end
        if (mMode == 0) begin
            if (mPending) begin
                mMode = 2; mAddr = 0; newPend = 0;
            end else if (acc && sof) begin
                eWe = 1; eAddr = 0; eData = data; mAddr = 1; mMode = 1;
            end
        end else if (mMode == 1) begin
            if (acc) begin
                eWe = 1; eData = data;
                if (sof && mAddr != 0) begin
                    eAddr = 0; mAddr = 1; eSe = 1;
                end else begin
                    eAddr = mAddr;
                    if (mAddr == P - 1) begin
                        eFd = 1; mCount = (mCount + 1) % 65536; mAddr = 0; mMode = 0;
                    end else begin
                        mAddr++;
                    end
                end
            end
        end else begin
            eWe = 1; eAddr = mAddr; eData = mColour;
            if (mAddr == P - 1) begin
                eFilld = 1; mAddr = 0; mMode = 0;
            end else begin
                mAddr++;
            end
        end
        mPending = newPend;
        mRstQ    = 0;
    endtask

    // One clock: drive at negedge, check ready/busy, advance model at posedge, check registers after it.
    task automatic applyStimulus(input bit rst, input bit valid, input bit sof, input logic [23:0] data,
                                 input bit freq, input logic [23:0] col);
        bit expReady, expBusy;
        @(negedge clock);
        reset = rst; pixValid = valid; pixSof = sof; pixData = data;
        fillReq = freq; fillColour = col;
        if (modelValid) begin
            expReady = !mRstQ && ((mMode == 0 && !mPending) || mMode == 1);
            expBusy  = mPending || mMode == 2;
            checkOutput("ready_busy", {62'b0, pixReady, fillBusy}, {62'b0, expReady, expBusy});
        end
        @(posedge clock);
        modelStep(rst, valid, sof, data, freq, col);
        modelValid = 1;
        cycle++;
        #1;
        checkOutput("write_port", {22'b0, writeEnable, writeAddress, writeData},
                    {22'b0, eWe, 17'(eAddr), eData});
        checkOutput("status", {45'b0, frameDone, fillDone, syncError, frameCount},
                    {45'b0, eFd, eFilld, eSe, 16'(mCount)});
        if (writeEnable === 1'b1) dutWrites++;
        if (writeEnable === 1'b1 && writeData === 24'h00FF00) greenWrites++;
        if (frameDone === 1'b1) begin dutFrameDones++; frameDoneCycle = cycle; end
        if (fillDone === 1'b1) begin dutFillDones++; fillDoneCycle = cycle; end
        if (syncError === 1'b1) dutSyncErrs++;
    endtask

    task automatic pixel(input bit sof, input logic [23:0] data);
        applyStimulus(0, 1, sof, data, 0, '0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, '0, 0, '0);
    endtask

    task automatic clearTallies();
        dutWrites = 0; dutFrameDones = 0; dutFillDones = 0; dutSyncErrs = 0; greenWrites = 0;
    endtask

    // Directed scenarios followed by a randomized soak.
    initial begin
        reset = 1; pixValid = 0; pixSof = 0; pixData = '0; fillReq = 0; fillColour = '0;
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, '0, 0, '0);
        idle(2);

        $display("[TB] clean frame");
        clearTallies();
        pixel(1, 24'd0);
        for (int i = 1; i < P; i++) pixel(0, 24'(i));
        idle(2);
        checkOutput("clean_frame_count", {48'b0, frameCount}, 64'd1);
        checkOutput("clean_frame_done_pulses", 64'(dutFrameDones), 64'd1);
        checkOutput("clean_frame_writes", 64'(dutWrites), 64'(P));

        $display("[TB] pre-SOF junk");
        clearTallies();
        for (int i = 0; i < 10; i++) pixel(0, 24'hABC000 + 24'(i));
        checkOutput("junk_writes", 64'(dutWrites), 64'd0);
        pixel(1, 24'h123456);
        checkOutput("junk_then_sof_addr", {47'b0, writeAddress}, 64'd0);
        for (int i = 1; i < P; i++) pixel(0, 24'(i));
        idle(1);

        $display("[TB] mid-frame resync");
        clearTallies();
        pixel(1, 24'd0);
        for (int i = 1; i < 10; i++) pixel(0, 24'(i));
        pixel(1, 24'h5A5A5A);
        for (int i = 1; i < P; i++) begin
            pixel(0, 24'h100 + 24'(i));
            if (i == 1) checkOutput("resync_next_addr", {47'b0, writeAddress}, 64'd1);
        end
        idle(1);
        checkOutput("resync_sync_pulses", 64'(dutSyncErrs), 64'd1);
        checkOutput("resync_frame_done_pulses", 64'(dutFrameDones), 64'd1);

        $display("[TB] fill during frame");
        clearTallies();
        pixel(1, 24'd0);
        for (int i = 1; i < P; i++) begin
            if (i == 5) applyStimulus(0, 1, 0, 24'(i), 1, 24'h00FF00);
            else pixel(0, 24'(i));
        end
        for (int i = 0; i < P + 4; i++) begin
            if (i == 10) applyStimulus(0, 1, 1, 24'h777777, 1, 24'hFF0000);
            else applyStimulus(0, 1, 0, 24'h777777, 0, '0);
        end
        checkOutput("fill_green_writes", 64'(greenWrites), 64'(P));
        checkOutput("fill_done_pulses", 64'(dutFillDones), 64'd1);

        $display("[TB] reset mid-fill");
        applyStimulus(0, 0, 0, '0, 1, 24'h0000FF);
        idle(1 + 13);
        applyStimulus(1, 0, 0, '0, 0, '0);
        checkOutput("reset_frame_count", {48'b0, frameCount}, 64'd0);
        idle(1);
        pixel(1, 24'h222222);
        checkOutput("after_reset_sof_addr", {47'b0, writeEnable, writeAddress}, {47'b0, 1'b1, 17'd0});
        for (int i = 1; i < P; i++) pixel(0, 24'(i));
        idle(2);

        $display("[TB] simultaneous fill and SOF");
        clearTallies();
        applyStimulus(0, 1, 1, 24'h010101, 1, 24'hC0FFEE);
        for (int i = 1; i < P; i++) pixel(0, 24'(i));
        idle(P + 4);
        // IDLE cycle, then FILL begins: first fill write lands 2 cycles after FrameDone, last one P-1 later.
        checkOutput("simul_done_spacing", 64'(fillDoneCycle - frameDoneCycle), 64'(P + 1));
        checkOutput("simul_order", 64'(dutFrameDones * 10 + dutFillDones), 64'd11);

        $display("[TB] randomized soak");
        for (int i = 0; i < 3000; i++) begin
            applyStimulus($urandom_range(0, 499) == 0,
                          ($urandom % 4) != 0,
                          $urandom_range(0, 39) == 0,
                          24'($urandom),
                          $urandom_range(0, 199) == 0,
                          24'($urandom));
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
